// File: rtl/matmul_output_serializer.sv
// ---------------------------------------------------------------------------
// matmul_output_serializer
//
// Captures all TOTAL_INPUT_W result vectors from the multi-matmul wrapper on
// the rising edge of acc_done. It then streams them out as OUT_W-bit beats
// over a valid/ready handshake, instance 0 first, chunk 0 first within each
// instance. In the cycle after a capture it sends a one-cycle mm_reset_acc
// pulse back to the wrapper, so the next accumulation can overlap the drain.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   acc_done      accumulator-done level from the wrapper (rising edge = capture)
//   in_vec        TOTAL_INPUT_W result vectors of VEC_W bits each
//   mm_reset_acc  one-cycle pulse to the wrapper reset_acc
//   m_valid/m_ready/m_data   output beat handshake and payload
//   busy          buffer still holds undrained beats
//   overrun       sticky: a capture request arrived while draining and was dropped
//
// Build option SERIALIZER_LAST_EN adds two ports:
//   m_last  marks the final beat of a frame
//   m_vec   instance index of the current beat
// ---------------------------------------------------------------------------
module matmul_output_serializer #(
    parameter int unsigned WIDTH_OUT     = 16,
    parameter int unsigned CHUNK_SIZE    = 4,
    parameter int unsigned NUM_CORES_A   = 4,
    parameter int unsigned NUM_CORES_B   = 1,
    parameter int unsigned TOTAL_MODULES = 2,
    parameter int unsigned TOTAL_INPUT_W = 2,
    localparam int unsigned OUT_W  = WIDTH_OUT * CHUNK_SIZE,
    localparam int unsigned BPI    = NUM_CORES_A * NUM_CORES_B * TOTAL_MODULES,
    localparam int unsigned VEC_W  = OUT_W * BPI,
    localparam int unsigned NBEATS = TOTAL_INPUT_W * BPI,
    localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1,
    localparam int unsigned VI_W   = (TOTAL_INPUT_W > 1) ? $clog2(TOTAL_INPUT_W) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             acc_done,
    input  logic [VEC_W-1:0] in_vec [TOTAL_INPUT_W],
    output logic             mm_reset_acc,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [OUT_W-1:0] m_data,
    output logic             busy,
`ifdef SERIALIZER_LAST_EN
    output logic             m_last,
    output logic [VI_W-1:0]  m_vec,
`endif
    output logic             overrun
);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             acc_done_q, acc_done_d;
    logic             overrun_q, overrun_d;
    logic             reset_acc_q, reset_acc_d;
    logic [OUT_W-1:0] beat_q [NBEATS];
    logic [OUT_W-1:0] beat_d [NBEATS];

    logic trig;
    logic accept;
    logic last_beat;
    logic load;

    assign trig      = acc_done & ~acc_done_q;
    assign accept    = (state_q == DRAIN) & m_ready;
    assign last_beat = (cnt_q == CNT_W'(NBEATS - 1));

    always_comb begin
        acc_done_d  = acc_done;
        state_d     = state_q;
        cnt_d       = cnt_q;
        overrun_d   = overrun_q;
        reset_acc_d = 1'b0;
        beat_d      = beat_q;
        load        = 1'b0;

        case (state_q)
            IDLE: begin
                if (trig) begin
                    load    = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (accept) begin
                    if (last_beat) begin
                        cnt_d = '0;
                        // A trigger coinciding with the final acceptance
                        // starts the next frame back-to-back.
                        if (trig) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                if (trig && !(accept && last_beat)) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flatten the capture so beat k = i*BPI + j maps directly to an entry.
        if (load) begin
            reset_acc_d = 1'b1;
            cnt_d       = '0;
            for (int unsigned i = 0; i < TOTAL_INPUT_W; i++) begin
                for (int unsigned j = 0; j < BPI; j++) begin
                    beat_d[i*BPI + j] = in_vec[i][j*OUT_W +: OUT_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_done_q  <= 1'b0;
            overrun_q   <= 1'b0;
            reset_acc_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_done_q  <= acc_done_d;
            overrun_q   <= overrun_d;
            reset_acc_q <= reset_acc_d;
        end
    end

    // Payload storage needs no reset: it is only visible while in DRAIN.
    always_ff @(posedge clk) begin
        beat_q <= beat_d;
    end

    assign m_valid      = (state_q == DRAIN);
    assign busy         = (state_q == DRAIN);
    assign m_data       = m_valid ? beat_q[cnt_q] : '0;
    assign mm_reset_acc = reset_acc_q;
    assign overrun      = overrun_q;

`ifdef SERIALIZER_LAST_EN
    assign m_last = m_valid & last_beat;
    assign m_vec  = m_valid ? VI_W'(32'(cnt_q) / BPI) : '0;
`endif

endmodule

// File: tb/tb_matmul_output_serializer.sv
module tb_matmul_output_serializer;

    localparam int OUT_W  = 64;
    localparam int BPI    = 8;
    localparam int VEC_W  = OUT_W * BPI;
    localparam int NBEATS = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             acc_done;
    logic [VEC_W-1:0] in_vec [2];
    logic             mm_reset_acc;
    logic             m_valid;
    logic             m_ready;
    logic [OUT_W-1:0] m_data;
    logic             busy;
    logic             overrun;
`ifdef SERIALIZER_LAST_EN
    logic             m_last;
    logic             m_vec;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int n_pulse = 0;
    int stall_err = 0;
    int cycles;
    logic             prev_stall = 1'b0;
    logic [OUT_W-1:0] prev_data = '0;
    logic [OUT_W-1:0] got_q [$];
    logic             last_q [$];
    logic             vec_q [$];

    matmul_output_serializer #(
        .WIDTH_OUT(16), .CHUNK_SIZE(4), .NUM_CORES_A(4), .NUM_CORES_B(1),
        .TOTAL_MODULES(2), .TOTAL_INPUT_W(2)
    ) dut (
        .clk(clk), .rst(rst), .acc_done(acc_done), .in_vec(in_vec),
        .mm_reset_acc(mm_reset_acc), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .busy(busy),
`ifdef SERIALIZER_LAST_EN
        .m_last(m_last), .m_vec(m_vec),
`endif
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Sample between edges: inputs are driven 1 ns after posedge.
    always @(negedge clk) begin
        if (mm_reset_acc) n_pulse++;
        if (prev_stall && (!m_valid || m_data != prev_data)) stall_err++;
        if (m_valid && m_ready) begin
            got_q.push_back(m_data);
`ifdef SERIALIZER_LAST_EN
            last_q.push_back(m_last);
            vec_q.push_back(m_vec);
`endif
        end
        prev_stall = m_valid && !m_ready && !rst;
        prev_data  = m_data;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] chunk(input int c);
        return {16'(c), 16'h1234, 16'hBEEF, 16'(c)};
    endfunction

    function automatic logic [63:0] exp_beat(input int base, input int k);
        return chunk(base + (k / BPI) * 16 + (k % BPI));
    endfunction

    task automatic load(input int base);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < BPI; j++)
                in_vec[i][j*OUT_W +: OUT_W] = chunk(base + i*16 + j);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input logic toggle_ready);
        cycles = 0;
        while (m_valid && cycles < 200) begin
            if (toggle_ready) m_ready = ~m_ready;
            step();
            cycles++;
        end
        chk("drain_timeout", 64'(cycles < 200), 64'd1);
    endtask

    task automatic check_frame(input string tag, input int start, input int base);
        for (int k = 0; k < NBEATS; k++)
            chk($sformatf("%s_b%0d", tag, k), got_q[start + k], exp_beat(base, k));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        acc_done = 1'b0;
        m_ready = 1'b0;
        in_vec[0] = '0;
        in_vec[1] = '0;
        step();
        step();
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_reset_acc", 64'(mm_reset_acc), 64'd0);
        chk("rst_data", m_data, 64'd0);
        rst = 1'b0;
        step();

        // 1: full-rate drain
        got_q.delete(); last_q.delete(); vec_q.delete(); n_pulse = 0;
        load(0);
        acc_done = 1'b1;
        m_ready = 1'b1;
        step();
        chk("t1_pulse", 64'(mm_reset_acc), 64'd1);
        chk("t1_valid", 64'(m_valid), 64'd1);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_first", m_data, exp_beat(0, 0));
        acc_done = 1'b0;
        wait_idle(1'b0);
        chk("t1_cycles", 64'(cycles), 64'd16);
        chk("t1_count", 64'(got_q.size()), 64'd16);
        check_frame("t1", 0, 0);
        chk("t1_npulse", 64'(n_pulse), 64'd1);
        chk("t1_busy_end", 64'(busy), 64'd0);
`ifdef SERIALIZER_LAST_EN
        for (int k = 0; k < NBEATS; k++) begin
            chk($sformatf("t6_last_b%0d", k), 64'(last_q[k]), 64'(k == NBEATS - 1));
            chk($sformatf("t6_vec_b%0d", k), 64'(vec_q[k]), 64'(k >= BPI));
        end
`endif

        // 2: ready toggling, acc_done held high throughout
        got_q.delete(); n_pulse = 0; stall_err = 0;
        load(0);
        acc_done = 1'b1;
        m_ready = 1'b0;
        step();
        wait_idle(1'b1);
        chk("t2_count", 64'(got_q.size()), 64'd16);
        check_frame("t2", 0, 0);
        chk("t2_stall_stable", 64'(stall_err), 64'd0);
        repeat (4) step();
        chk("t2_held_no_recapture", 64'(m_valid), 64'd0);
        chk("t2_npulse", 64'(n_pulse), 64'd1);
        chk("t2_no_overrun", 64'(overrun), 64'd0);
        acc_done = 1'b0;
        m_ready = 1'b1;
        step();

        // 3: second edge at beat 5 is dropped
        got_q.delete(); n_pulse = 0;
        load(8'h40);
        acc_done = 1'b1;
        step();
        acc_done = 1'b0;
        repeat (5) step();
        chk("t3_at_beat5", m_data, exp_beat(8'h40, 5));
        load(8'hC0);
        acc_done = 1'b1;
        step();
        acc_done = 1'b0;
        chk("t3_overrun", 64'(overrun), 64'd1);
        wait_idle(1'b0);
        chk("t3_count", 64'(got_q.size()), 64'd16);
        check_frame("t3", 0, 8'h40);
        chk("t3_npulse", 64'(n_pulse), 64'd1);
        chk("t3_sticky", 64'(overrun), 64'd1);

        // 5: reset mid-drain clears everything, next capture restarts at beat 0
        load(0);
        acc_done = 1'b1;
        step();
        acc_done = 1'b0;
        repeat (7) step();
        chk("t5_at_beat7", m_data, exp_beat(0, 7));
        rst = 1'b1;
        step();
        chk("t5_valid", 64'(m_valid), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_overrun", 64'(overrun), 64'd0);
        chk("t5_data", m_data, 64'd0);
        rst = 1'b0;
        step();
        got_q.delete();
        load(8'h30);
        acc_done = 1'b1;
        step();
        acc_done = 1'b0;
        chk("t5_restart", m_data, exp_beat(8'h30, 0));
        wait_idle(1'b0);
        chk("t5_count", 64'(got_q.size()), 64'd16);
        check_frame("t5", 0, 8'h30);

        // 4: edge coinciding with final-beat acceptance chains a new frame
        step();
        got_q.delete(); n_pulse = 0;
        load(8'h60);
        acc_done = 1'b1;
        step();
        acc_done = 1'b0;
        repeat (15) step();
        chk("t4_at_beat15", m_data, exp_beat(8'h60, 15));
        load(8'hA0);
        acc_done = 1'b1;
        step();
        acc_done = 1'b0;
        chk("t4_valid", 64'(m_valid), 64'd1);
        chk("t4_next", m_data, exp_beat(8'hA0, 0));
        chk("t4_pulse", 64'(mm_reset_acc), 64'd1);
        chk("t4_overrun", 64'(overrun), 64'd0);
        wait_idle(1'b0);
        chk("t4_count", 64'(got_q.size()), 64'd32);
        check_frame("t4a", 0, 8'h60);
        check_frame("t4b", 16, 8'hA0);
        chk("t4_npulse", 64'(n_pulse), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
